// File: rtl/growing_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | growing_pkg: shared defaults and state encoding for the           |
// | down-averaging / up-interpolating chain.                          |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package growing_pkg;

    localparam int c_n_default  = 16;
    localparam int c_nw_default = 3;
    // Segment counter width: covers the largest ratio R = 128.
    localparam int c_kw         = 7;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        EMIT  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/interp_mac.sv
`default_nettype none
// +------------------------------------------------------------------+
// | interp_mac: combinational linear-interpolation datapath           |
// | y = prev + floor((curr - prev) * k / 2^s), truncated to N bits.   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module interp_mac
    import growing_pkg::*;
#(
    parameter int N  = c_n_default,
    parameter int NW = c_nw_default
) (
    input  logic [N-1:0]    prev,
    input  logic [N-1:0]    curr,
    input  logic [c_kw-1:0] k,
    input  logic [NW-1:0]   s,
    output logic [N-1:0]    y
);

    logic signed [N:0]      w_diff;
    logic signed [N+c_kw:0] w_diff_x;
    logic signed [N+c_kw:0] w_k_x;
    logic signed [N+c_kw:0] w_prod;
    logic        [N-1:0]    w_step;

    assign w_diff   = $signed({1'b0, curr}) - $signed({1'b0, prev});
    assign w_diff_x = $signed({{c_kw{w_diff[N]}}, w_diff});
    assign w_k_x    = $signed({{(N + 1){1'b0}}, k});
    assign w_prod   = w_diff_x * w_k_x;

    // Arithmetic shift floors negative steps; the sum always lands between
    // prev and curr, so modular N-bit addition is exact.
    assign w_step   = N'(w_prod >>> s);
    assign y        = prev + w_step;

endmodule
`default_nettype wire

// File: rtl/growing_interp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | growing_interp: upsamples a decimated stream by R = 2^N_UPS_in    |
// | using linear interpolation between consecutive samples.           |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module growing_interp
    import growing_pkg::*;
#(
    parameter int N  = c_n_default,
    parameter int NW = c_nw_default
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    input  logic [N-1:0]  x,
    output logic          ready,
    input  logic [NW-1:0] N_UPS_in,
    output logic [N-1:0]  y,
    output logic          new_dat
);

    localparam logic [c_kw-1:0] c_k_one = 1;
    localparam logic [c_kw:0]   c_m_one = 1;

    state_t          r_state, w_state_nxt;
    logic [N-1:0]    r_prev, w_prev_nxt;
    logic [N-1:0]    r_curr, w_curr_nxt;
    logic [c_kw-1:0] r_k, w_k_nxt;
    logic [NW-1:0]   r_s, w_s_nxt;
    logic [N-1:0]    r_y;
    logic            r_new_dat;
    logic [N-1:0]    w_mac_y;
    logic [c_kw:0]   w_mask;
    logic            w_last;
    logic            w_emit;
    logic            w_ready;

    interp_mac #(
        .N  (N),
        .NW (NW)
    ) u_mac (
        .prev (r_prev),
        .curr (r_curr),
        .k    (r_k),
        .s    (r_s),
        .y    (w_mac_y)
    );

    // Last sample of a segment when k reaches 2^s - 1.
    assign w_mask = (c_m_one << r_s) - c_m_one;
    assign w_last = ({1'b0, r_k} == w_mask);

    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev;
        w_curr_nxt  = r_curr;
        w_k_nxt     = r_k;
        w_s_nxt     = r_s;
        w_ready     = 1'b0;
        w_emit      = 1'b0;
        case (r_state)
            EMPTY: begin
                w_ready = 1'b1;
                if (valid) begin
                    w_prev_nxt  = x;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                w_ready = 1'b1;
                if (valid) begin
                    w_curr_nxt  = x;
                    w_k_nxt     = '0;
                    w_s_nxt     = N_UPS_in;
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                w_emit  = 1'b1;
                w_ready = w_last;
                if (w_last) begin
                    w_prev_nxt = r_curr;
                    if (valid) begin
                        // Chain straight into the next segment without a gap.
                        w_curr_nxt = x;
                        w_k_nxt    = '0;
                        w_s_nxt    = N_UPS_in;
                    end else begin
                        w_state_nxt = HOLD;
                    end
                end else begin
                    w_k_nxt = r_k + c_k_one;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= EMPTY;
            r_prev    <= '0;
            r_curr    <= '0;
            r_k       <= '0;
            r_s       <= '0;
            r_y       <= '0;
            r_new_dat <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_prev    <= w_prev_nxt;
            r_curr    <= w_curr_nxt;
            r_k       <= w_k_nxt;
            r_s       <= w_s_nxt;
            r_new_dat <= w_emit;
            if (w_emit) begin
                r_y <= w_mac_y;
            end
        end
    end

    assign ready   = w_ready;
    assign y       = r_y;
    assign new_dat = r_new_dat;

endmodule
`default_nettype wire

// File: tb/tb_growing_interp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_growing_interp: directed self-checking bench for growing_interp|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_growing_interp;
    import growing_pkg::*;

    localparam int N  = 16;
    localparam int NW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic [N-1:0]  x;
    logic          ready;
    logic [NW-1:0] n_ups;
    logic [N-1:0]  y;
    logic          new_dat;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [31:0] q_y[$];
    int          q_c[$];

    always #5 clk = ~clk;

    growing_interp #(
        .N  (N),
        .NW (NW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .x        (x),
        .ready    (ready),
        .N_UPS_in (n_ups),
        .y        (y),
        .new_dat  (new_dat)
    );

    // Collect every strobed output sample with its cycle stamp.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (new_dat === 1'b1) begin
            q_y.push_back({16'd0, y});
            q_c.push_back(cyc);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qv(input int i);
        if (i < q_y.size()) return q_y[i];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic int qgap(input int a, input int b);
        if (b < q_c.size()) return q_c[b] - q_c[a];
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present v and return on the negedge after it has been accepted.
    task automatic send(input logic [N-1:0] v);
        int t;
        valid = 1'b1;
        x     = v;
        t     = 0;
        while (ready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t = t + 1;
        end
        if (t >= 300) begin
            tests = tests + 1;
            fails = fails + 1;
            $error("FAIL send_timeout: observed no ready required ready for %0d", v);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        valid = 1'b0;
        rst   = 1'b1;
        tick(2);
        rst   = 1'b0;
        q_y.delete();
        q_c.delete();
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        x     = '0;
        n_ups = '0;
        tick(3);
        check("rst_y", {16'd0, y}, 32'd0);
        check("rst_new_dat", {31'd0, new_dat}, 32'd0);
        rst = 1'b0;
        tick(1);
        check("rst_ready", {31'd0, ready}, 32'd1);

        // R = 2, back-to-back inputs
        do_reset();
        n_ups = 3'd1;
        send(16'd0); send(16'd10); send(16'd20); send(16'd20);
        valid = 1'b0;
        tick(6);
        check("r2_count", q_y.size(), 32'd6);
        check("r2_y0", qv(0), 32'd0);
        check("r2_y1", qv(1), 32'd5);
        check("r2_y2", qv(2), 32'd10);
        check("r2_y3", qv(3), 32'd15);
        check("r2_y4", qv(4), 32'd20);
        check("r2_y5", qv(5), 32'd20);
        check("r2_contig", qgap(0, 5), 32'd5);

        // R = 4, descending, then input stops
        do_reset();
        n_ups = 3'd2;
        send(16'd100); send(16'd0);
        valid = 1'b0;
        tick(8);
        check("r4_count", q_y.size(), 32'd4);
        check("r4_y0", qv(0), 32'd100);
        check("r4_y1", qv(1), 32'd75);
        check("r4_y2", qv(2), 32'd50);
        check("r4_y3", qv(3), 32'd25);
        check("r4_state", {30'd0, dut.r_state}, {30'd0, HOLD});
        check("r4_ready", {31'd0, ready}, 32'd1);
        check("r4_new_dat", {31'd0, new_dat}, 32'd0);

        // R = 1 streaming
        do_reset();
        n_ups = 3'd0;
        send(16'd1); send(16'd2);
        check("r1_ready_a", {31'd0, ready}, 32'd1);
        send(16'd3);
        check("r1_ready_b", {31'd0, ready}, 32'd1);
        send(16'd4);
        check("r1_ready_c", {31'd0, ready}, 32'd1);
        valid = 1'b0;
        tick(4);
        check("r1_count", q_y.size(), 32'd3);
        check("r1_y0", qv(0), 32'd1);
        check("r1_y1", qv(1), 32'd2);
        check("r1_y2", qv(2), 32'd3);
        check("r1_contig", qgap(0, 2), 32'd2);

        // R = 128, full-scale step
        do_reset();
        n_ups = 3'd7;
        send(16'd0); send(16'd65535);
        valid = 1'b0;
        tick(135);
        check("r128_count", q_y.size(), 32'd128);
        check("r128_y0", qv(0), 32'd0);
        check("r128_y64", qv(64), 32'd32767);
        check("r128_y127", qv(127), 32'd65023);

        // R = 2, full-scale fall: floor on negative step
        do_reset();
        n_ups = 3'd1;
        send(16'd65535); send(16'd0);
        valid = 1'b0;
        tick(4);
        check("fall_count", q_y.size(), 32'd2);
        check("fall_y0", qv(0), 32'd65535);
        check("fall_y1", qv(1), 32'd32767);

        // Reset in the middle of an R = 8 segment
        do_reset();
        n_ups = 3'd3;
        send(16'd0); send(16'd80);
        valid = 1'b0;
        tick(3);
        check("mid_k", {25'd0, dut.r_k}, 32'd3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_y", {16'd0, y}, 32'd0);
        check("mid_rst_new_dat", {31'd0, new_dat}, 32'd0);
        check("mid_rst_ready", {31'd0, ready}, 32'd1);
        tick(6);
        check("mid_rst_count", q_y.size(), 32'd3);
        q_y.delete();
        q_c.delete();
        send(16'd8); send(16'd16);
        valid = 1'b0;
        tick(10);
        check("after_rst_count", q_y.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("after_rst_y%0d", i), qv(i), 32'd8 + 32'(i));
        end

        // Ratio change mid-segment takes effect at the next latch
        do_reset();
        n_ups = 3'd2;
        send(16'd0); send(16'd40);
        n_ups = 3'd1;
        send(16'd80);
        valid = 1'b0;
        tick(8);
        check("chg_count", q_y.size(), 32'd6);
        check("chg_y0", qv(0), 32'd0);
        check("chg_y1", qv(1), 32'd10);
        check("chg_y2", qv(2), 32'd20);
        check("chg_y3", qv(3), 32'd30);
        check("chg_y4", qv(4), 32'd40);
        check("chg_y5", qv(5), 32'd60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
